data_memory_responder: RTL and testbench

- Data-memory responder for the CPU's data bus (address, write data, write enable, read data).
- Owns an on-chip byte RAM and sequences its life cycle: clear the RAM, preload a data image from the host, serve CPU reads and writes while the program runs, then stream the full RAM contents back to the host once the CPU signals that the process has finished.
- Sits between the CPU top level and the host/test harness. It runs on the CPU clock.

---
 rtl/data_memory_responder_if.sv | 34 +++
 rtl/data_memory_responder.sv | 147 ++++++++++++++
 tb/tb_data_memory_responder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// Bus bundle between the CPU/host harness and the data-memory responder.
// The responder uses the slave modport; the CPU/host side uses master.
interface data_memory_responder_if;
   logic [15:0] CPU_ADDRESS;
   logic [7:0]  CPU_DATA;
   logic        CPU_WRITE_EN;
   logic        PROCESS_FINISHED;
   logic [7:0]  DATA_FROM_RAM;
   logic        MEM_READY;
   logic        OOR_ERR;
   logic [7:0]  HOST_DATA;
   logic        HOST_VALID;
   logic        HOST_LAST;
   logic        HOST_READY;
   logic [7:0]  DUMP_DATA;
   logic        DUMP_VALID;
   logic        DUMP_LAST;
   logic        DUMP_READY;
   logic [2:0]  STATE;

   modport master (
      output CPU_ADDRESS, CPU_DATA, CPU_WRITE_EN, PROCESS_FINISHED,
      output HOST_DATA, HOST_VALID, HOST_LAST, DUMP_READY,
      input  DATA_FROM_RAM, MEM_READY, OOR_ERR, HOST_READY,
      input  DUMP_DATA, DUMP_VALID, DUMP_LAST, STATE
   );

   modport slave (
      input  CPU_ADDRESS, CPU_DATA, CPU_WRITE_EN, PROCESS_FINISHED,
      input  HOST_DATA, HOST_VALID, HOST_LAST, DUMP_READY,
      output DATA_FROM_RAM, MEM_READY, OOR_ERR, HOST_READY,
      output DUMP_DATA, DUMP_VALID, DUMP_LAST, STATE
   );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: clears the byte RAM, preloads it from the host,
// serves CPU accesses while running, then streams the RAM back to the host.
module data_memory_responder #(
   parameter int unsigned ADDR_W      = 8,
   parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
   input logic                   CLOCK,
   input logic                   RESET,
   data_memory_responder_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_DUMP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]   w_ptr_nxt;
   logic                r_oor;
   logic                w_oor_nxt;
   logic [7:0]          r_mem [DEPTH];

   logic                w_in_range;
   logic [ADDR_W-1:0]   w_cpu_idx;
   logic                w_we;
   logic [ADDR_W-1:0]   w_waddr;
   logic [7:0]          w_wdata;

   logic [7:0]          w_rd_data;
   logic                w_mem_ready;
   logic                w_host_ready;
   logic [7:0]          w_dump_data;
   logic                w_dump_valid;
   logic                w_dump_last;

   assign w_in_range = (bus.CPU_ADDRESS[15:ADDR_W] == '0);
   assign w_cpu_idx  = bus.CPU_ADDRESS[ADDR_W-1:0];

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state <= S_CLEAR;
         r_ptr   <= '0;
         r_oor   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_oor   <= w_oor_nxt;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_oor_nxt    = r_oor;
      w_we         = 1'b0;
      w_waddr      = r_ptr;
      w_wdata      = CLEAR_VALUE;
      w_rd_data    = 8'h00;
      w_mem_ready  = 1'b0;
      w_host_ready = 1'b0;
      w_dump_data  = 8'h00;
      w_dump_valid = 1'b0;
      w_dump_last  = 1'b0;

      case (r_state)
         S_CLEAR: begin
            w_we      = 1'b1;
            w_ptr_nxt = r_ptr + ADDR_W'(1);
            if (r_ptr == '1) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_host_ready = 1'b1;
            if (bus.HOST_VALID) begin
               w_we      = 1'b1;
               w_wdata   = bus.HOST_DATA;
               w_ptr_nxt = r_ptr + ADDR_W'(1);
               if (bus.HOST_LAST) begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            w_mem_ready = 1'b1;
            // The read port is always live in RUN, so an out-of-range address
            // counts as an access even without a write strobe.
            if (w_in_range) begin
               w_rd_data = r_mem[w_cpu_idx];
               if (bus.CPU_WRITE_EN) begin
                  w_we    = 1'b1;
                  w_waddr = w_cpu_idx;
                  w_wdata = bus.CPU_DATA;
               end
            end else begin
               w_oor_nxt = 1'b1;
            end
            if (bus.PROCESS_FINISHED) begin
               w_state_nxt = S_DUMP;
               w_ptr_nxt   = '0;
            end
         end
         S_DUMP: begin
            w_dump_valid = 1'b1;
            w_dump_data  = r_mem[r_ptr];
            w_dump_last  = (r_ptr == '1);
            if (bus.DUMP_READY) begin
               w_ptr_nxt = r_ptr + ADDR_W'(1);
               if (r_ptr == '1) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
         end
         default: begin
            w_state_nxt = S_CLEAR;
            w_ptr_nxt   = '0;
         end
      endcase

      if (RESET) begin
         w_we = 1'b0;
      end
   end

   assign bus.DATA_FROM_RAM = w_rd_data;
   assign bus.MEM_READY     = w_mem_ready;
   assign bus.OOR_ERR       = r_oor;
   assign bus.HOST_READY    = w_host_ready;
   assign bus.DUMP_DATA     = w_dump_data;
   assign bus.DUMP_VALID    = w_dump_valid;
   assign bus.DUMP_LAST     = w_dump_last;
   assign bus.STATE         = r_state;
endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (ADDR_W=4): clear, preload,
// CPU access, dump with back-pressure, load wrap and reset mid-dump.
module tb_data_memory_responder;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] model [DEPTH];
   logic [7:0] exp_q [$];
   int         load_ptr;

   data_memory_responder_if bus();

   data_memory_responder #(.ADDR_W(AW), .CLEAR_VALUE(8'h00)) dut (
      .CLOCK(clk),
      .RESET(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.CPU_ADDRESS      = 16'h0000;
      bus.CPU_DATA         = 8'h00;
      bus.CPU_WRITE_EN     = 1'b0;
      bus.PROCESS_FINISHED = 1'b0;
      bus.HOST_DATA        = 8'h00;
      bus.HOST_VALID       = 1'b0;
      bus.HOST_LAST        = 1'b0;
      bus.DUMP_READY       = 1'b0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
      load_ptr = 0;
   endtask

   task automatic host_send(input logic [7:0] d, input logic last);
      bus.HOST_DATA  = d;
      bus.HOST_VALID = 1'b1;
      bus.HOST_LAST  = last;
      model[load_ptr] = d;
      load_ptr = (load_ptr + 1) % DEPTH;
      tick();
      bus.HOST_VALID = 1'b0;
      bus.HOST_LAST  = 1'b0;
   endtask

   task automatic test_reset();
      int cnt;
      rst = 1'b1;
      tick();
      tick();
      checks++; if (bus.STATE !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", bus.STATE); end
      checks++; if (bus.HOST_READY !== 1'b0) begin failures++; $display("FAIL reset_host_ready: got %b expected 0", bus.HOST_READY); end
      checks++; if (bus.DUMP_VALID !== 1'b0 || bus.DUMP_LAST !== 1'b0 || bus.DUMP_DATA !== 8'h00) begin failures++; $display("FAIL reset_dump: got v=%b l=%b d=%h expected 0/0/00", bus.DUMP_VALID, bus.DUMP_LAST, bus.DUMP_DATA); end
      checks++; if (bus.MEM_READY !== 1'b0 || bus.DATA_FROM_RAM !== 8'h00) begin failures++; $display("FAIL reset_cpu: got rdy=%b d=%h expected 0/00", bus.MEM_READY, bus.DATA_FROM_RAM); end
      checks++; if (bus.OOR_ERR !== 1'b0) begin failures++; $display("FAIL reset_oor: got %b expected 0", bus.OOR_ERR); end
      rst = 1'b0;
      clear_model();
      cnt = 0;
      while (bus.STATE === 3'd0 && cnt < 40) begin
         cnt++;
         tick();
      end
      checks++; if (cnt !== 16) begin failures++; $display("FAIL clear_cycles: got %0d expected 16", cnt); end
      checks++; if (bus.STATE !== 3'd1) begin failures++; $display("FAIL clear_to_load: got %0d expected 1", bus.STATE); end
      checks++; if (bus.HOST_READY !== 1'b1) begin failures++; $display("FAIL load_host_ready: got %b expected 1", bus.HOST_READY); end
   endtask

   task automatic test_preload();
      host_send(8'hA1, 1'b0);
      checks++; if (bus.STATE !== 3'd1) begin failures++; $display("FAIL preload_stay_load: got %0d expected 1", bus.STATE); end
      tick();
      bus.HOST_LAST = 1'b1;
      tick();
      bus.HOST_LAST = 1'b0;
      checks++; if (bus.STATE !== 3'd1) begin failures++; $display("FAIL ghost_last: got %0d expected 1", bus.STATE); end
      host_send(8'hB2, 1'b0);
      tick();
      tick();
      host_send(8'hC3, 1'b1);
      checks++; if (bus.STATE !== 3'd2) begin failures++; $display("FAIL preload_to_run: got %0d expected 2", bus.STATE); end
      checks++; if (bus.MEM_READY !== 1'b1 || bus.HOST_READY !== 1'b0) begin failures++; $display("FAIL run_ready: got mem=%b host=%b expected 1/0", bus.MEM_READY, bus.HOST_READY); end
   endtask

   task automatic test_read_all(input string tag);
      logic [7:0] e;
      bus.CPU_WRITE_EN = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         bus.CPU_ADDRESS = 16'(a);
         exp_q.push_back(model[a]);
         #1;
         e = exp_q.pop_front();
         checks++; if (bus.DATA_FROM_RAM !== e) begin failures++; $display("FAIL read_%s[%0d]: got %h expected %h", tag, a, bus.DATA_FROM_RAM, e); end
      end
      checks++; if (bus.MEM_READY !== 1'b1) begin failures++; $display("FAIL read_%s_mem_ready: got %b expected 1", tag, bus.MEM_READY); end
   endtask

   task automatic test_cpu_access();
      bus.CPU_ADDRESS  = 16'h0007;
      bus.CPU_DATA     = 8'h5A;
      bus.CPU_WRITE_EN = 1'b1;
      #1;
      checks++; if (bus.DATA_FROM_RAM !== 8'h00) begin failures++; $display("FAIL write_same_cycle: got %h expected 00", bus.DATA_FROM_RAM); end
      tick();
      bus.CPU_WRITE_EN = 1'b0;
      model[7] = 8'h5A;
      #1;
      checks++; if (bus.DATA_FROM_RAM !== 8'h5A) begin failures++; $display("FAIL write_next_cycle: got %h expected 5a", bus.DATA_FROM_RAM); end
      checks++; if (bus.OOR_ERR !== 1'b0) begin failures++; $display("FAIL oor_before: got %b expected 0", bus.OOR_ERR); end
      bus.CPU_ADDRESS  = 16'h0010;
      bus.CPU_DATA     = 8'h77;
      bus.CPU_WRITE_EN = 1'b1;
      #1;
      checks++; if (bus.DATA_FROM_RAM !== 8'h00) begin failures++; $display("FAIL oor_read_0010: got %h expected 00", bus.DATA_FROM_RAM); end
      tick();
      bus.CPU_WRITE_EN = 1'b0;
      checks++; if (bus.OOR_ERR !== 1'b1) begin failures++; $display("FAIL oor_set: got %b expected 1", bus.OOR_ERR); end
      bus.CPU_ADDRESS = 16'h0100;
      #1;
      checks++; if (bus.DATA_FROM_RAM !== 8'h00) begin failures++; $display("FAIL oor_read_0100: got %h expected 00", bus.DATA_FROM_RAM); end
      bus.CPU_ADDRESS = 16'h0000;
   endtask

   task automatic test_finish_dump();
      int n;
      int cyc;
      logic [7:0] e;
      bus.CPU_ADDRESS      = 16'h0003;
      bus.CPU_DATA         = 8'h3C;
      bus.CPU_WRITE_EN     = 1'b1;
      bus.PROCESS_FINISHED = 1'b1;
      tick();
      bus.CPU_WRITE_EN     = 1'b0;
      bus.PROCESS_FINISHED = 1'b0;
      bus.CPU_ADDRESS      = 16'h0000;
      model[3] = 8'h3C;
      checks++; if (bus.STATE !== 3'd3) begin failures++; $display("FAIL finish_to_dump: got %0d expected 3", bus.STATE); end
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(model[i]);
      n = 0;
      cyc = 0;
      while (bus.STATE === 3'd3 && cyc < 100) begin
         bus.DUMP_READY = (cyc % 2 == 1);
         #1;
         e = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
         checks++; if (bus.DUMP_VALID !== 1'b1) begin failures++; $display("FAIL dump_valid[%0d]: got %b expected 1", n, bus.DUMP_VALID); end
         checks++; if (bus.DUMP_DATA !== e) begin failures++; $display("FAIL dump_data[%0d]: got %h expected %h", n, bus.DUMP_DATA, e); end
         checks++; if (bus.DUMP_LAST !== (n == 15)) begin failures++; $display("FAIL dump_last[%0d]: got %b expected %b", n, bus.DUMP_LAST, (n == 15)); end
         if (bus.DUMP_READY && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n++;
         end
         tick();
         cyc++;
      end
      bus.DUMP_READY = 1'b0;
      checks++; if (n !== 16) begin failures++; $display("FAIL dump_count: got %0d expected 16", n); end
      checks++; if (bus.STATE !== 3'd4) begin failures++; $display("FAIL dump_to_done: got %0d expected 4", bus.STATE); end
      checks++; if (bus.DUMP_VALID !== 1'b0 || bus.DUMP_LAST !== 1'b0) begin failures++; $display("FAIL done_dump_outputs: got v=%b l=%b expected 0/0", bus.DUMP_VALID, bus.DUMP_LAST); end
      checks++; if (bus.MEM_READY !== 1'b0) begin failures++; $display("FAIL done_mem_ready: got %b expected 0", bus.MEM_READY); end
      checks++; if (bus.OOR_ERR !== 1'b1) begin failures++; $display("FAIL done_oor_hold: got %b expected 1", bus.OOR_ERR); end
      exp_q.delete();
      tick();
      tick();
      tick();
      checks++; if (bus.STATE !== 3'd4 || bus.HOST_READY !== 1'b0) begin failures++; $display("FAIL done_stays: got st=%0d hr=%b expected 4/0", bus.STATE, bus.HOST_READY); end
   endtask

   task automatic test_load_wrap();
      int cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_model();
      checks++; if (bus.OOR_ERR !== 1'b0) begin failures++; $display("FAIL wrap_oor_cleared: got %b expected 0", bus.OOR_ERR); end
      cnt = 0;
      while (bus.STATE !== 3'd1 && cnt < 40) begin
         cnt++;
         tick();
      end
      checks++; if (bus.STATE !== 3'd1) begin failures++; $display("FAIL wrap_reach_load: got %0d expected 1", bus.STATE); end
      for (int i = 0; i < 18; i++) host_send(8'(i), (i == 17));
      checks++; if (bus.STATE !== 3'd2) begin failures++; $display("FAIL wrap_to_run: got %0d expected 2", bus.STATE); end
      test_read_all("wrap");
      bus.CPU_ADDRESS = 16'h0100;
      tick();
      bus.CPU_ADDRESS = 16'h0000;
      checks++; if (bus.OOR_ERR !== 1'b1) begin failures++; $display("FAIL wrap_oor_set: got %b expected 1", bus.OOR_ERR); end
   endtask

   task automatic test_reset_mid_dump();
      int cnt;
      logic [7:0] e;
      bus.PROCESS_FINISHED = 1'b1;
      tick();
      bus.PROCESS_FINISHED = 1'b0;
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(model[i]);
      bus.DUMP_READY = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         e = exp_q.pop_front();
         checks++; if (bus.DUMP_DATA !== e) begin failures++; $display("FAIL middump_data[%0d]: got %h expected %h", k, bus.DUMP_DATA, e); end
         tick();
      end
      bus.DUMP_READY = 1'b0;
      exp_q.delete();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_model();
      checks++; if (bus.STATE !== 3'd0) begin failures++; $display("FAIL middump_reset_state: got %0d expected 0", bus.STATE); end
      checks++; if (bus.DUMP_VALID !== 1'b0) begin failures++; $display("FAIL middump_reset_valid: got %b expected 0", bus.DUMP_VALID); end
      checks++; if (bus.OOR_ERR !== 1'b0) begin failures++; $display("FAIL middump_reset_oor: got %b expected 0", bus.OOR_ERR); end
      cnt = 0;
      while (bus.STATE === 3'd0 && cnt < 40) begin
         cnt++;
         tick();
      end
      checks++; if (cnt !== 16) begin failures++; $display("FAIL reclear_cycles: got %0d expected 16", cnt); end
      checks++; if (bus.STATE !== 3'd1) begin failures++; $display("FAIL reclear_to_load: got %0d expected 1", bus.STATE); end
      host_send(8'hEE, 1'b1);
      checks++; if (bus.STATE !== 3'd2) begin failures++; $display("FAIL single_load_to_run: got %0d expected 2", bus.STATE); end
      test_read_all("reclear");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_preload();
      test_read_all("preload");
      test_cpu_access();
      test_read_all("after_cpu");
      test_finish_dump();
      test_load_wrap();
      test_reset_mid_dump();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
